// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: fixed-point Mandelbrot iteration engine.
// Iterates z <- z^2 + c from z0 = 0 for one point c = re + i*im per request.
// Each iteration takes two cycles (MUL, ADD). The engine reports the escape
// iteration count, or ITER_MAX when the point stays bounded.
// Optional build macro MANDEL_PERIOD_CHECK_EN adds Brent-style cycle
// detection. A detected cycle ends the request early on interior points.
// With this option the results are unchanged and only the latency differs.
module mandel_iter_engine #(
  parameter  int FP_WIDTH = 25,
  parameter  int FP_INT   = 4,
  parameter  int ITER_MAX = 255,
  localparam int ITERW    = $clog2(ITER_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [FP_WIDTH-1:0] re,
  input  logic signed [FP_WIDTH-1:0] im,
  output logic [ITERW-1:0]           iter,
  output logic                       calculating,
  output logic                       done
);

  localparam int FRAC = FP_WIDTH - FP_INT;
  localparam int PW   = 2 * FP_WIDTH;

  localparam logic [ITERW-1:0] ITER_MAX_W = ITERW'(ITER_MAX);
  // 4.0 in the 2*FRAC product format, one bit wider than a product so that
  // the sum of two squares cannot wrap.
  localparam logic signed [PW:0] MAG_LIMIT = (PW + 1)'(4) <<< (2 * FRAC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic signed [FP_WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [FP_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic signed [PW-1:0]       xx_q, xx_d, yy_q, yy_d, xy_q, xy_d;
  logic [ITERW-1:0]           n_q, n_d;
  logic [ITERW-1:0]           iter_q, iter_d;

  // Datapath terms shared by the ADD state.
  logic signed [PW-1:0]       x_ext, y_ext;
  logic signed [PW:0]         mag, diff;
  logic signed [FP_WIDTH-1:0] new_x, new_y;
  logic [ITERW-1:0]           n_inc;
  logic                       n_inc_pow2;

  assign x_ext = PW'(x_q);
  assign y_ext = PW'(y_q);

  // The squares are kept at full width, so the escape test sees the true magnitude
  // even when the next z would overflow FP_WIDTH.
  assign mag  = (PW + 1)'(xx_q) + (PW + 1)'(yy_q);
  assign diff = (PW + 1)'(xx_q) - (PW + 1)'(yy_q);

  // Rescale to FRAC fractional bits. The shift is arithmetic (floor), and the
  // high bits are dropped. 2xy uses one bit less of shift than the squares.
  assign new_x = FP_WIDTH'(diff >>> FRAC) + cr_q;
  assign new_y = FP_WIDTH'(xy_q >>> (FRAC - 1)) + ci_q;

  assign n_inc      = n_q + ITERW'(1);
  assign n_inc_pow2 = ((n_inc & (n_inc - ITERW'(1))) == '0);

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [FP_WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                       cycle_hit;

  assign cycle_hit = (new_x == sx_q) && (new_y == sy_q);
`endif

  // Next-state and datapath control for the IDLE/MUL/ADD/DONE sequence.
  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    x_d     = x_q;
    y_d     = y_q;
    xx_d    = xx_q;
    yy_d    = yy_q;
    xy_d    = xy_q;
    n_d     = n_q;
    iter_d  = iter_q;
`ifdef MANDEL_PERIOD_CHECK_EN
    sx_d    = sx_q;
    sy_d    = sy_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cr_d    = re;
          ci_d    = im;
          x_d     = '0;
          y_d     = '0;
          n_d     = '0;
`ifdef MANDEL_PERIOD_CHECK_EN
          sx_d    = '0;
          sy_d    = '0;
`endif
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        xx_d    = x_ext * x_ext;
        yy_d    = y_ext * y_ext;
        xy_d    = x_ext * y_ext;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (mag > MAG_LIMIT) begin
          iter_d  = n_q;
          state_d = S_DONE;
        end else if (n_q == ITER_MAX_W) begin
          iter_d  = ITER_MAX_W;
          state_d = S_DONE;
        end else begin
`ifdef MANDEL_PERIOD_CHECK_EN
          if (cycle_hit) begin
            // The orbit revisited the snapshot, so the point is interior.
            iter_d  = ITER_MAX_W;
            state_d = S_DONE;
          end else begin
            x_d     = new_x;
            y_d     = new_y;
            n_d     = n_inc;
            state_d = S_MUL;
            if (n_inc_pow2) begin
              sx_d = new_x;
              sy_d = new_y;
            end
          end
`else
          x_d     = new_x;
          y_d     = new_y;
          n_d     = n_inc;
          state_d = S_MUL;
`endif
        end
      end
      default: begin
        // DONE: one-cycle result pulse. start is ignored here.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any request in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cr_q    <= '0;
      ci_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xx_q    <= '0;
      yy_q    <= '0;
      xy_q    <= '0;
      n_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xx_q    <= xx_d;
      yy_q    <= yy_d;
      xy_q    <= xy_d;
      n_q     <= n_d;
      iter_q  <= iter_d;
    end
  end

`ifdef MANDEL_PERIOD_CHECK_EN
  // Snapshot of z, refreshed whenever the iteration count reaches a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end
`endif

  assign iter        = iter_q;
  assign done        = (state_q == S_DONE);
  assign calculating = (state_q != S_IDLE);

endmodule
